// File: rtl/nibble_serial_tx.sv
// nibble_serial_tx: 4-bit serial transmitter, start/LSB-first data/
// optional even parity/stop framing.
// Ports: clk, reset (async, active-low), tx_data/tx_valid/tx_ready
// upstream handshake, tx_line serial out, busy, done (1-cycle pulse).
module nibble_serial_tx #(
   parameter int CLKS_PER_BIT = 4,
   parameter int PARITY_EN    = 0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx_line,
   output logic       busy,
   output logic       done
);

   localparam int CW = $clog2(CLKS_PER_BIT + 1);
   localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   state_t          state;
   state_t          state_n;
   logic [CW-1:0]   cnt;
   logic [CW-1:0]   cnt_n;
   logic [1:0]      idx;
   logic [1:0]      idx_n;
   logic [3:0]      shreg;
   logic [3:0]      shreg_n;
   logic            line_n;
   logic            bit_end;

   // Counter runs down from RELOAD; zero marks the last cycle of a bit.
   assign bit_end  = (cnt == '0);
   assign tx_ready = (state == IDLE);
   assign busy     = (state != IDLE);
   assign done     = (state == STOP) && bit_end;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         cnt     <= '0;
         idx     <= '0;
         shreg   <= '0;
         tx_line <= 1'b1;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         idx     <= idx_n;
         shreg   <= shreg_n;
         tx_line <= line_n;
      end
   end

   // The line value is computed for the next state so that tx_line
   // itself is a flop and changes in step with the state.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      idx_n   = idx;
      shreg_n = shreg;
      line_n  = tx_line;
      if (state != IDLE) begin
         cnt_n = bit_end ? RELOAD : cnt - CW'(1);
      end
      unique case (state)
         IDLE: begin
            line_n = 1'b1;
            if (tx_valid) begin
               state_n = START;
               cnt_n   = RELOAD;
               shreg_n = tx_data;
               idx_n   = '0;
               line_n  = 1'b0;
            end
         end
         START: begin
            if (bit_end) begin
               state_n = DATA;
               idx_n   = '0;
               line_n  = shreg[0];
            end
         end
         DATA: begin
            if (bit_end) begin
               if (idx == 2'd3) begin
                  if (PARITY_EN != 0) begin
                     state_n = PARITY;
                     line_n  = ^shreg;
                  end else begin
                     state_n = STOP;
                     line_n  = 1'b1;
                  end
               end else begin
                  idx_n  = idx + 2'd1;
                  line_n = shreg[idx_n];
               end
            end
         end
         PARITY: begin
            if (bit_end) begin
               state_n = STOP;
               line_n  = 1'b1;
            end
         end
         STOP: begin
            if (bit_end) begin
               state_n = IDLE;
               line_n  = 1'b1;
            end
         end
         default: begin
            state_n = IDLE;
            line_n  = 1'b1;
         end
      endcase
   end

endmodule
